lsu_mem_access: RTL and testbench

- Load/store unit in the MEM stage; consumes the decoder's write_ram_flag / load_ram_flag encodings plus the ALU address.
- Turns them into word-wide data-RAM bus transactions: byte strobes, lane replication, load extraction and sign/zero extension.
- Stalls the pipeline until the access completes; reports misalignment and bus timeout.

---
 rtl/lsu_mem_access.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_access.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// Load/store unit, MEM stage.
// Turns decoded store/load requests into single word-wide data-RAM bus
// transactions: byte strobes and lane replication for stores, lane
// extraction with sign/zero extension for loads. The pipeline is held
// while the access is outstanding. Misaligned accesses and bus timeouts
// finish with a one-cycle done pulse plus an error flag.
module lsu_mem_access #(
    parameter int TIMEOUT = 16  // REQ cycles without bus_ack before abort; 0 disables
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stage_valid,
    input  logic [1:0]  write_ram_flag,
    input  logic [2:0]  load_ram_flag,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Access size encoding shared by stores and loads.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit             TMO_EN   = (TIMEOUT > 0);
    localparam logic [CW-1:0]  TMO_LAST = TMO_EN ? CW'(TIMEOUT - 1) : '0;

    logic [1:0]    state;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_sd;
    logic          cap_we;
    logic [1:0]    cap_size;
    logic          cap_signed;
    logic          err_mis;
    logic [CW-1:0] tmo_cnt;

    logic          is_store;
    logic          is_load;
    logic [1:0]    in_size;
    logic          in_signed;
    logic          misaligned;
    logic          start;
    logic          timeout_hit;
    logic [3:0]    st_strb;
    logic [31:0]   st_wdata;
    logic [31:0]   rd_shift;
    logic [31:0]   ld_ext;

    // Decode the incoming flags; a store takes priority over a load.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        is_store  = (write_ram_flag != 2'b00);
        is_load   = 1'b0;
        in_size   = SZ_W;
        in_signed = 1'b0;
        if (is_store) begin
            case (write_ram_flag)
                2'b10:   in_size = SZ_H;
                2'b11:   in_size = SZ_B;
                default: in_size = SZ_W;
            endcase
        end else begin
            case (load_ram_flag)
                3'b001: begin is_load = 1'b1; in_size = SZ_W; end
                3'b110: begin is_load = 1'b1; in_size = SZ_H; in_signed = 1'b1; end
                3'b010: begin is_load = 1'b1; in_size = SZ_H; end
                3'b111: begin is_load = 1'b1; in_size = SZ_B; in_signed = 1'b1; end
                3'b011: begin is_load = 1'b1; in_size = SZ_B; end
                default: is_load = 1'b0;
            endcase
        end
        misaligned = ((in_size == SZ_W) && (addr[1:0] != 2'b00)) ||
                     ((in_size == SZ_H) && addr[0]);
    end

    assign start       = (state == S_IDLE) && stage_valid && (is_store || is_load);
    assign timeout_hit = TMO_EN && (tmo_cnt == TMO_LAST);

    // FSM, capture registers, timeout counter and the load result register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: capture registers are reset too, so the bus outputs and load_data read 0 out of reset.
        if (!rst_n) begin
            state      <= S_IDLE;
            cap_addr   <= '0;
            cap_sd     <= '0;
            cap_we     <= 1'b0;
            cap_size   <= SZ_B;
            cap_signed <= 1'b0;
            err_mis    <= 1'b0;
            tmo_cnt    <= '0;
            load_data  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cap_addr   <= addr;
                        cap_sd     <= store_data;
                        cap_we     <= is_store;
                        cap_size   <= in_size;
                        cap_signed <= in_signed;
                        err_mis    <= misaligned;
                        tmo_cnt    <= '0;
                        state      <= misaligned ? S_ERR : S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        if (!cap_we) begin
                            load_data <= ld_ext;
                        end
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        err_mis <= 1'b0;
                        state   <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;  // DONE and ERR last one cycle
            endcase
        end
    end

    // Store lane replication and byte strobes from the captured op.
    always_comb begin
        st_strb  = 4'b0000;
        st_wdata = cap_sd;
        case (cap_size)
            SZ_B: begin
                st_strb  = 4'b0001 << cap_addr[1:0];
                st_wdata = {4{cap_sd[7:0]}};
            end
            SZ_H: begin
                st_strb  = cap_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{cap_sd[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = cap_sd;
            end
        endcase
    end

    // Load lane extraction with sign or zero extension.
    always_comb begin
        rd_shift = bus_rdata >> {cap_addr[1:0], 3'b000};
        ld_ext   = bus_rdata;
        case (cap_size)
            SZ_B:    ld_ext = {{24{cap_signed & rd_shift[7]}}, rd_shift[7:0]};
            SZ_H:    ld_ext = {{16{cap_signed & rd_shift[15]}}, rd_shift[15:0]};
            default: ld_ext = bus_rdata;
        endcase
    end

    assign mem_stall    = start || (state == S_REQ);
    assign bus_req      = (state == S_REQ);
    assign bus_we       = bus_req && cap_we;
    assign bus_addr     = {cap_addr[31:2], 2'b00};
    assign bus_wstrb    = bus_we ? st_strb  : 4'b0000;
    assign bus_wdata    = bus_we ? st_wdata : 32'h0;
    assign done         = (state == S_DONE) || (state == S_ERR);
    assign misalign_err = (state == S_ERR) && err_mis;
    assign bus_err      = (state == S_ERR) && !err_mis;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with TIMEOUT=4: a table of store and
// load vectors plus hand-written misalign, timeout and reset sequences.
module tb_lsu_mem_access;

    localparam logic [31:0] RDATA = 32'h80F07F01;

    logic        clk;
    logic        rst_n;
    logic        stage_valid;
    logic [1:0]  write_ram_flag;
    logic [2:0]  load_ram_flag;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_stall;
    logic        done;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ld   = 32'h0;

    typedef struct {
        logic [1:0]  wf;
        logic [2:0]  lf;
        logic [31:0] addr;
        logic [31:0] sd;
        int          wait_n;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[16];

    lsu_mem_access #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stage_valid    (stage_valid),
        .write_ram_flag (write_ram_flag),
        .load_ram_flag  (load_ram_flag),
        .addr           (addr),
        .store_data     (store_data),
        .mem_stall      (mem_stall),
        .done           (done),
        .load_data      (load_data),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wstrb      (bus_wstrb),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stage_valid    = 1'b0;
        write_ram_flag = 2'b00;
        load_ram_flag  = 3'b000;
        addr           = 32'h0;
        store_data     = 32'h0;
    endtask

    // Present one legal access in an IDLE cycle and follow it to DONE.
    task automatic run_access(input vec_t v, input int idx);
        stage_valid    = 1'b1;
        write_ram_flag = v.wf;
        load_ram_flag  = v.lf;
        addr           = v.addr;
        store_data     = v.sd;
        bus_rdata      = RDATA;
        #1;
        check($sformatf("v%0d start stall", idx), 32'(mem_stall), 32'd1);
        check($sformatf("v%0d start no req", idx), 32'(bus_req), 32'd0);
        for (int c = 0; c <= v.wait_n; c++) begin
            tick();
            bus_ack = (c == v.wait_n);
            check($sformatf("v%0d req%0d bus_req", idx, c), 32'(bus_req), 32'd1);
            check($sformatf("v%0d req%0d stall", idx, c), 32'(mem_stall), 32'd1);
            check($sformatf("v%0d req%0d done", idx, c), 32'(done), 32'd0);
            if (c == 0) begin
                check($sformatf("v%0d bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
                check($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.wf != 2'b00));
                check($sformatf("v%0d wstrb", idx), 32'(bus_wstrb), 32'(v.strb));
                if (v.wf != 2'b00)
                    check($sformatf("v%0d wdata", idx), bus_wdata, v.wdata);
            end
        end
        tick();
        bus_ack = 1'b0;
        if (v.wf == 2'b00) exp_ld = v.ld;
        check($sformatf("v%0d done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d done stall", idx), 32'(mem_stall), 32'd0);
        check($sformatf("v%0d done bus_req", idx), 32'(bus_req), 32'd0);
        check($sformatf("v%0d misalign_err", idx), 32'(misalign_err), 32'd0);
        check($sformatf("v%0d bus_err", idx), 32'(bus_err), 32'd0);
        check($sformatf("v%0d load_data", idx), load_data, exp_ld);
        idle_inputs();
    endtask

    // Misaligned access: no bus cycle, error completion the next cycle.
    task automatic run_misaligned(input logic [1:0] wf, input logic [2:0] lf,
                                  input logic [31:0] a, input string name);
        stage_valid    = 1'b1;
        write_ram_flag = wf;
        load_ram_flag  = lf;
        addr           = a;
        store_data     = 32'h55AA55AA;
        #1;
        check({name, " start stall"}, 32'(mem_stall), 32'd1);
        tick();
        check({name, " no bus_req"}, 32'(bus_req), 32'd0);
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " misalign_err"}, 32'(misalign_err), 32'd1);
        check({name, " bus_err"}, 32'(bus_err), 32'd0);
        check({name, " stall drops"}, 32'(mem_stall), 32'd0);
        idle_inputs();
        tick();
        check({name, " done clears"}, 32'(done), 32'd0);
        check({name, " misalign clears"}, 32'(misalign_err), 32'd0);
        check({name, " still no req"}, 32'(bus_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        bit seen_done;

        //        wf     lf      addr          sd            wait strb   wdata         ld
        vecs[0]  = '{2'b01, 3'b000, 32'h00000100, 32'hDEADBEEF, 0, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{2'b11, 3'b000, 32'h00000103, 32'h000000A5, 0, 4'h8, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{2'b10, 3'b000, 32'h00000102, 32'h00001234, 0, 4'hC, 32'h12341234, 32'h0};
        vecs[3]  = '{2'b11, 3'b000, 32'h00000101, 32'hFFFFFF3C, 1, 4'h2, 32'h3C3C3C3C, 32'h0};
        vecs[4]  = '{2'b10, 3'b000, 32'h00000200, 32'hABCD5678, 2, 4'h3, 32'h56785678, 32'h0};
        vecs[5]  = '{2'b11, 3'b001, 32'h00000201, 32'h00000077, 0, 4'h2, 32'h77777777, 32'h0};
        vecs[6]  = '{2'b01, 3'b000, 32'h00000040, 32'h11223344, 3, 4'hF, 32'h11223344, 32'h0};
        vecs[7]  = '{2'b00, 3'b111, 32'h00000000, 32'h0, 3, 4'h0, 32'h0, 32'h00000001};
        vecs[8]  = '{2'b00, 3'b111, 32'h00000003, 32'h0, 3, 4'h0, 32'h0, 32'hFFFFFF80};
        vecs[9]  = '{2'b00, 3'b011, 32'h00000003, 32'h0, 3, 4'h0, 32'h0, 32'h00000080};
        vecs[10] = '{2'b00, 3'b110, 32'h00000002, 32'h0, 3, 4'h0, 32'h0, 32'hFFFF80F0};
        vecs[11] = '{2'b00, 3'b010, 32'h00000002, 32'h0, 3, 4'h0, 32'h0, 32'h000080F0};
        vecs[12] = '{2'b00, 3'b001, 32'h00000000, 32'h0, 3, 4'h0, 32'h0, 32'h80F07F01};
        vecs[13] = '{2'b00, 3'b111, 32'h00000001, 32'h0, 0, 4'h0, 32'h0, 32'h0000007F};
        vecs[14] = '{2'b00, 3'b110, 32'h00000000, 32'h0, 1, 4'h0, 32'h0, 32'h00007F01};
        vecs[15] = '{2'b00, 3'b011, 32'h00000002, 32'h0, 2, 4'h0, 32'h0, 32'h000000F0};

        rst_n     = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = RDATA;
        idle_inputs();
        tick();
        tick();
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst stall", 32'(mem_stall), 32'd0);
        check("rst load_data", load_data, 32'h0);
        check("rst bus_addr", bus_addr, 32'h0);
        check("rst wstrb", 32'(bus_wstrb), 32'd0);
        check("rst wdata", bus_wdata, 32'h0);
        check("rst errs", 32'({misalign_err, bus_err, bus_we}), 32'd0);
        rst_n = 1'b1;
        tick();

        // A load flag of 100 is not a legal load: nothing starts.
        stage_valid   = 1'b1;
        load_ram_flag = 3'b100;
        #1;
        check("illegal lf stall", 32'(mem_stall), 32'd0);
        tick();
        check("illegal lf no req", 32'(bus_req), 32'd0);
        idle_inputs();
        tick();

        for (int i = 0; i < 16; i++) begin
            run_access(vecs[i], i);
            tick();
            check($sformatf("v%0d idle done", i), 32'(done), 32'd0);
        end

        run_misaligned(2'b00, 3'b001, 32'h00000102, "mis lw");
        run_misaligned(2'b10, 3'b000, 32'h00000101, "mis sh");
        run_misaligned(2'b00, 3'b010, 32'h00000003, "mis lhu");

        // Timeout: no ack ever, bus_req must be high exactly TIMEOUT cycles.
        stage_valid    = 1'b1;
        write_ram_flag = 2'b01;
        addr           = 32'h00000300;
        store_data     = 32'hCAFEF00D;
        req_cycles     = 0;
        seen_done      = 1'b0;
        for (int i = 0; i < 12 && !seen_done; i++) begin
            tick();
            if (bus_req) req_cycles++;
            if (done) begin
                seen_done = 1'b1;
                check("tmo bus_err", 32'(bus_err), 32'd1);
                check("tmo misalign_err", 32'(misalign_err), 32'd0);
                check("tmo stall", 32'(mem_stall), 32'd0);
                check("tmo load_data kept", load_data, exp_ld);
            end
        end
        check("tmo done seen", 32'(seen_done), 32'd1);
        check("tmo req cycles", 32'(req_cycles), 32'd4);
        idle_inputs();
        tick();
        check("tmo after bus_req", 32'(bus_req), 32'd0);
        check("tmo after done", 32'(done), 32'd0);
        check("tmo after bus_err", 32'(bus_err), 32'd0);

        // Reset in the middle of a REQ: bus_req drops at once, no done.
        stage_valid   = 1'b1;
        load_ram_flag = 3'b001;
        addr          = 32'h00000010;
        tick();
        check("mid rst req before", 32'(bus_req), 32'd1);
        tick();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("mid rst req async", 32'(bus_req), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst load_data", load_data, 32'h0);
        exp_ld = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid rst hold%0d done", i), 32'(done | bus_req), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Back-to-back store then load after reset.
        run_access(vecs[0], 100);
        tick();
        run_access(vecs[12], 101);
        tick();
        check("b2b idle done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
